// File: rtl/demux_1_to_2_reg_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer.
package demux_1_to_2_reg_pkg;

  // Select encoding matches the 2:1 mux: 0 steers to channel 1, 1 to channel 2.
  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : demux_1_to_2_reg_pkg

// File: rtl/demux_1_to_2_reg_channel.sv
// One destination of the demux: holding register, valid flag and an
// overwrite indication for writes that land on unconsumed data.
module demux_channel_reg
  import demux_1_to_2_reg_pkg::*;
#(
  parameter int unsigned WIDTH             = DEFAULT_WIDTH,
  parameter bit          ZERO_WHEN_INVALID = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_write,
  input  logic             i_consume,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overwrite
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Valid flag is the channel state (0 = IDLE, 1 = HELD); a write always
  // wins over a same-edge consume, and consume on IDLE is a no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_write) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Overwrite only when held data is replaced without being taken this edge.
  assign o_overwrite = i_write & r_valid & ~i_consume;

  // Gating affects the visible output only; r_data still holds the last value.
  always_comb begin
    o_data = r_data;
    if (ZERO_WHEN_INVALID && !r_valid) o_data = '0;
  end

  assign o_valid = r_valid;

endmodule : demux_channel_reg

// File: rtl/demux_1_to_2_reg.sv
// Registered 1-to-2 demultiplexer: steers inputValue into one of two
// holding registers with valid/consume handshakes and a sticky overflow.
module demux_1_to_2_reg
  import demux_1_to_2_reg_pkg::*;
#(
  parameter int unsigned WIDTH             = DEFAULT_WIDTH,
  parameter int unsigned ZERO_WHEN_INVALID = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inputValue,
  input  logic             select,
  input  logic             writeEnable,
  input  logic             consume1,
  input  logic             consume2,
  input  logic             clearOverflow,
  output logic [WIDTH-1:0] output1,
  output logic [WIDTH-1:0] output2,
  output logic             valid1,
  output logic             valid2,
  output logic             full,
  output logic             overflow
);

  localparam bit ZWI = (ZERO_WHEN_INVALID != 0);

  logic w_wr1;
  logic w_wr2;
  logic w_ovw1;
  logic w_ovw2;
  logic r_overflow;

  assign w_wr1 = writeEnable & (select == SEL_OUT1);
  assign w_wr2 = writeEnable & (select == SEL_OUT2);

  demux_channel_reg #(
    .WIDTH             (WIDTH),
    .ZERO_WHEN_INVALID (ZWI)
  ) u_ch1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (inputValue),
    .i_write     (w_wr1),
    .i_consume   (consume1),
    .o_data      (output1),
    .o_valid     (valid1),
    .o_overwrite (w_ovw1)
  );

  demux_channel_reg #(
    .WIDTH             (WIDTH),
    .ZERO_WHEN_INVALID (ZWI)
  ) u_ch2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (inputValue),
    .i_write     (w_wr2),
    .i_consume   (consume2),
    .o_data      (output2),
    .o_valid     (valid2),
    .o_overwrite (w_ovw2)
  );

  // Sticky overflow; a new overwrite on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovw1 || w_ovw2) begin
      r_overflow <= 1'b1;
    end else if (clearOverflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
  assign full     = valid1 & valid2;

endmodule : demux_1_to_2_reg

// File: tb/tb_demux_1_to_2_reg.sv
// Directed-vector and reference-model bench for demux_1_to_2_reg; drives a
// held-value instance and a zero-when-invalid instance with the same stimulus.
module tb_demux_1_to_2_reg;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] inputValue;
  logic         select, writeEnable, consume1, consume2, clearOverflow;

  logic [W-1:0] o1_h, o2_h, o1_z, o2_z;
  logic         v1_h, v2_h, full_h, ovf_h;
  logic         v1_z, v2_z, full_z, ovf_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1_to_2_reg #(.WIDTH(W), .ZERO_WHEN_INVALID(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .inputValue(inputValue), .select(select),
    .writeEnable(writeEnable), .consume1(consume1), .consume2(consume2),
    .clearOverflow(clearOverflow), .output1(o1_h), .output2(o2_h),
    .valid1(v1_h), .valid2(v2_h), .full(full_h), .overflow(ovf_h)
  );

  demux_1_to_2_reg #(.WIDTH(W), .ZERO_WHEN_INVALID(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .inputValue(inputValue), .select(select),
    .writeEnable(writeEnable), .consume1(consume1), .consume2(consume2),
    .clearOverflow(clearOverflow), .output1(o1_z), .output2(o2_z),
    .valid1(v1_z), .valid2(v2_z), .full(full_z), .overflow(ovf_z)
  );

  typedef struct {
    logic         we;
    logic         sel;
    logic [W-1:0] d;
    logic         c1;
    logic         c2;
    logic         clr;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic         v1;
    logic         v2;
    logic         full;
    logic         ovf;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic sel, input logic [W-1:0] d,
                       input logic c1, input logic c2, input logic clr);
    writeEnable   = we;
    select        = sel;
    inputValue    = d;
    consume1      = c1;
    consume2      = c2;
    clearOverflow = clr;
  endtask

  // Reference model state for the random phase
  logic [W-1:0] m_o1, m_o2;
  logic         m_v1, m_v2, m_ovf;

  initial begin
    // we sel d    c1 c2 clr | o1    o2    v1 v2 full ovf
    vecs[0]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 8'h11, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 8'h11, 8'h42, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_h", {o1_h, o2_h, v1_h, v2_h, full_h, ovf_h}, '0);
    chk("reset_z", {o1_z, o2_z, v1_z, v2_z, full_z, ovf_z}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].sel, vecs[i].d, vecs[i].c1, vecs[i].c2, vecs[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out1", i), o1_h, vecs[i].o1);
      chk($sformatf("vec%0d_out2", i), o2_h, vecs[i].o2);
      chk($sformatf("vec%0d_valid", i), {v1_h, v2_h}, {vecs[i].v1, vecs[i].v2});
      chk($sformatf("vec%0d_full", i), full_h, vecs[i].full);
      chk($sformatf("vec%0d_ovf", i), ovf_h, vecs[i].ovf);
      chk($sformatf("vec%0d_zout1", i), o1_z, vecs[i].v1 ? vecs[i].o1 : 8'h00);
      chk($sformatf("vec%0d_zout2", i), o2_z, vecs[i].v2 ? vecs[i].o2 : 8'h00);
      chk($sformatf("vec%0d_zflags", i), {v1_z, v2_z, full_z, ovf_z},
          {vecs[i].v1, vecs[i].v2, vecs[i].full, vecs[i].ovf});
    end

    // Build up state with overflow, then assert reset between clock edges
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h98, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_state", {o1_h, o2_h, v1_h, v2_h, full_h, ovf_h},
        {8'h98, 8'h42, 1'b1, 1'b1, 1'b1, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_h", {o1_h, o2_h, v1_h, v2_h, full_h, ovf_h}, '0);
    chk("async_reset_z", {o1_z, o2_z, v1_z, v2_z, full_z, ovf_z}, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Random phase against a reference model
    m_o1 = '0; m_o2 = '0; m_v1 = 1'b0; m_v2 = 1'b0; m_ovf = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic         we, sel, c1, c2, clr, ow;
      logic [W-1:0] d;
      @(negedge clk);
      we  = ($urandom_range(0, 99) < 60);
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      c1  = ($urandom_range(0, 99) < 35);
      c2  = ($urandom_range(0, 99) < 35);
      clr = ($urandom_range(0, 99) < 20);
      drive(we, sel, d, c1, c2, clr);
      ow = (we && !sel && m_v1 && !c1) || (we && sel && m_v2 && !c2);
      if (we && !sel) begin m_o1 = d; m_v1 = 1'b1; end
      else if (c1)    m_v1 = 1'b0;
      if (we && sel)  begin m_o2 = d; m_v2 = 1'b1; end
      else if (c2)    m_v2 = 1'b0;
      if (ow)         m_ovf = 1'b1;
      else if (clr)   m_ovf = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d_h", n), {o1_h, o2_h, v1_h, v2_h, full_h, ovf_h},
          {m_o1, m_o2, m_v1, m_v2, m_v1 & m_v2, m_ovf});
      chk($sformatf("rand%0d_z", n), {o1_z, o2_z, v1_z, v2_z, full_z, ovf_z},
          {m_v1 ? m_o1 : 8'h00, m_v2 ? m_o2 : 8'h00, m_v1, m_v2, m_v1 & m_v2, m_ovf});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux_1_to_2_reg
